// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_pipe
//  Description : Parametrised three-stage IEEE-754-style floating-point
//                multiplier (multiply / normalise / round-pack) with
//                valid/ready handshakes and full exception flags.
//                Subnormal inputs are flushed to zero; subnormal outputs are
//                never produced.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+FRC_W:0]     fp_X,
    input  logic [EXP_W+FRC_W:0]     fp_Y,
    input  logic [2:0]               r_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRC_W:0]     fp_Z,
    output logic                     ovrf,
    output logic                     udrf,
    output logic                     nx,
    output logic                     nv
);

    localparam int c_W  = 1 + EXP_W + FRC_W;
    localparam int c_PW = 2 * FRC_W + 2;
    localparam int c_EW = EXP_W + 2;

    localparam logic [c_EW-1:0]  c_BIAS     = c_EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic [c_EW-1:0]  c_EMAX     = c_EW'((2 ** EXP_W) - 1);
    localparam logic [c_EW-1:0]  c_ONE      = c_EW'(1);
    localparam logic [c_EW-1:0]  c_ZERO_E   = '0;
    localparam logic [EXP_W-1:0] c_EXP_ONES = {EXP_W{1'b1}};
    localparam logic [c_W-1:0]   c_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};

    localparam logic [2:0] c_RNE = 3'b000;
    localparam logic [2:0] c_RTZ = 3'b001;
    localparam logic [2:0] c_RDN = 3'b010;
    localparam logic [2:0] c_RUP = 3'b011;
    localparam logic [2:0] c_RMM = 3'b100;

    // ------------------------------------------------------------------
    // Handshake: a stage may load when empty or when the next one moves.
    // ------------------------------------------------------------------
    logic r1_v, r2_v, r3_v;
    logic w_en1, w_en2, w_en3;

    assign w_en3    = !r3_v || out_ready;
    assign w_en2    = !r2_v || w_en3;
    assign w_en1    = !r1_v || w_en2;
    assign in_ready = w_en1;

    // ------------------------------------------------------------------
    // Stage 1 combinational: classify operands, multiply significands.
    // ------------------------------------------------------------------
    logic             w_sx, w_sy, w_s;
    logic [EXP_W-1:0] w_ex, w_ey;
    logic [FRC_W-1:0] w_fx, w_fy;
    logic             w_x_zero, w_x_inf, w_x_nan, w_x_snan;
    logic             w_y_zero, w_y_inf, w_y_nan, w_y_snan;
    logic [c_PW-1:0]  w_p;
    logic [c_EW-1:0]  w_e1;
    logic             w_spc, w_spc_nv;
    logic [c_W-1:0]   w_spc_z;

    assign w_sx = fp_X[c_W-1];
    assign w_sy = fp_Y[c_W-1];
    assign w_ex = fp_X[c_W-2:FRC_W];
    assign w_ey = fp_Y[c_W-2:FRC_W];
    assign w_fx = fp_X[FRC_W-1:0];
    assign w_fy = fp_Y[FRC_W-1:0];
    assign w_s  = w_sx ^ w_sy;

    assign w_x_zero = (w_ex == '0);
    assign w_y_zero = (w_ey == '0);
    assign w_x_inf  = (w_ex == c_EXP_ONES) && (w_fx == '0);
    assign w_y_inf  = (w_ey == c_EXP_ONES) && (w_fy == '0);
    assign w_x_nan  = (w_ex == c_EXP_ONES) && (w_fx != '0);
    assign w_y_nan  = (w_ey == c_EXP_ONES) && (w_fy != '0);
    assign w_x_snan = w_x_nan && !w_fx[FRC_W-1];
    assign w_y_snan = w_y_nan && !w_fy[FRC_W-1];

    assign w_p  = c_PW'({1'b1, w_fx}) * c_PW'({1'b1, w_fy});
    assign w_e1 = {2'b00, w_ex} + {2'b00, w_ey} - c_BIAS;

    // Special-case result selection; NaN takes precedence over inf*zero.
    always_comb begin
        w_spc    = 1'b1;
        w_spc_nv = 1'b0;
        w_spc_z  = '0;
        if (w_x_nan || w_y_nan) begin
            w_spc_z  = c_QNAN;
            w_spc_nv = w_x_snan || w_y_snan;
        end else if ((w_x_inf && w_y_zero) || (w_y_inf && w_x_zero)) begin
            w_spc_z  = c_QNAN;
            w_spc_nv = 1'b1;
        end else if (w_x_inf || w_y_inf) begin
            w_spc_z  = {w_s, c_EXP_ONES, {FRC_W{1'b0}}};
        end else if (w_x_zero || w_y_zero) begin
            w_spc_z  = {w_s, {(c_W-1){1'b0}}};
        end else begin
            w_spc    = 1'b0;
        end
    end

    logic [c_PW-1:0] r1_p;
    logic [c_EW-1:0] r1_e;
    logic            r1_s, r1_spc, r1_spc_nv;
    logic [2:0]      r1_mode;
    logic [c_W-1:0]  r1_spc_z;

    // Stage 1 registers: product, biased exponent sum, sign, mode, specials.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_v      <= 1'b0;
            r1_p      <= '0;
            r1_e      <= '0;
            r1_s      <= 1'b0;
            r1_mode   <= '0;
            r1_spc    <= 1'b0;
            r1_spc_nv <= 1'b0;
            r1_spc_z  <= '0;
        end else if (w_en1) begin
            r1_v <= in_valid;
            if (in_valid) begin
                r1_p      <= w_p;
                r1_e      <= w_e1;
                r1_s      <= w_s;
                r1_mode   <= r_mode;
                r1_spc    <= w_spc;
                r1_spc_nv <= w_spc_nv;
                r1_spc_z  <= w_spc_z;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: normalise to [1,2) and split off G/R/S.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] w_norm;
    logic [c_EW-1:0] w_e2;

    assign w_norm = r1_p[c_PW-1] ? r1_p : {r1_p[c_PW-2:0], 1'b0};
    assign w_e2   = r1_p[c_PW-1] ? (r1_e + c_ONE) : r1_e;

    logic [FRC_W:0]  r2_sig;
    logic            r2_g, r2_r, r2_st;
    logic [c_EW-1:0] r2_e;
    logic            r2_s, r2_spc, r2_spc_nv;
    logic [2:0]      r2_mode;
    logic [c_W-1:0]  r2_spc_z;

    // Stage 2 registers: normalised significand, rounding bits, exponent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_v      <= 1'b0;
            r2_sig    <= '0;
            r2_g      <= 1'b0;
            r2_r      <= 1'b0;
            r2_st     <= 1'b0;
            r2_e      <= '0;
            r2_s      <= 1'b0;
            r2_mode   <= '0;
            r2_spc    <= 1'b0;
            r2_spc_nv <= 1'b0;
            r2_spc_z  <= '0;
        end else if (w_en2) begin
            r2_v <= r1_v;
            if (r1_v) begin
                r2_sig    <= w_norm[c_PW-1:FRC_W+1];
                r2_g      <= w_norm[FRC_W];
                r2_r      <= w_norm[FRC_W-1];
                r2_st     <= |w_norm[FRC_W-2:0];
                r2_e      <= w_e2;
                r2_s      <= r1_s;
                r2_mode   <= r1_mode;
                r2_spc    <= r1_spc;
                r2_spc_nv <= r1_spc_nv;
                r2_spc_z  <= r1_spc_z;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 combinational: round, detect overflow/underflow, pack.
    // ------------------------------------------------------------------
    logic [2:0]       w_mode;
    logic             w_lost, w_inc, w_carry, w_to_inf;
    logic [FRC_W-1:0] w_frac;
    logic [c_EW-1:0]  w_e3;
    logic [c_W-1:0]   w_z;
    logic             w_ovf, w_udf, w_nx, w_nv;

    assign w_mode = (r_mode_ok(r2_mode)) ? r2_mode : c_RNE;
    assign w_lost = r2_g || r2_r || r2_st;

    function automatic logic r_mode_ok(input logic [2:0] m);
        return (m <= c_RMM);
    endfunction

    // Increment decision and overflow direction per rounding mode.
    always_comb begin
        w_inc    = 1'b0;
        w_to_inf = 1'b1;
        case (w_mode)
            c_RNE: begin w_inc = r2_g && (r2_r || r2_st || r2_sig[0]); w_to_inf = 1'b1;  end
            c_RTZ: begin w_inc = 1'b0;                                 w_to_inf = 1'b0;  end
            c_RDN: begin w_inc = r2_s && w_lost;                       w_to_inf = r2_s;  end
            c_RUP: begin w_inc = !r2_s && w_lost;                      w_to_inf = !r2_s; end
            default: begin w_inc = r2_g;                               w_to_inf = 1'b1;  end
        endcase
    end

    // The significand always carries a leading 1, so all-ones plus one is
    // the only carry case; the fraction then wraps to zero on its own.
    assign w_carry = w_inc && (&r2_sig);
    assign w_frac  = r2_sig[FRC_W-1:0] + {{(FRC_W-1){1'b0}}, w_inc};
    assign w_e3    = w_carry ? (r2_e + c_ONE) : r2_e;

    // Final result and flag selection.
    always_comb begin
        w_z   = {r2_s, w_e3[EXP_W-1:0], w_frac};
        w_ovf = 1'b0;
        w_udf = 1'b0;
        w_nx  = w_lost;
        w_nv  = 1'b0;
        if (r2_spc) begin
            w_z  = r2_spc_z;
            w_nx = 1'b0;
            w_nv = r2_spc_nv;
        end else if ($signed(w_e3) >= $signed(c_EMAX)) begin
            w_ovf = 1'b1;
            w_nx  = 1'b1;
            w_z   = w_to_inf ? {r2_s, c_EXP_ONES, {FRC_W{1'b0}}}
                             : {r2_s, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
        end else if ($signed(w_e3) <= $signed(c_ZERO_E)) begin
            w_udf = 1'b1;
            w_nx  = 1'b1;
            w_z   = {r2_s, {(c_W-1){1'b0}}};
        end
    end

    logic [c_W-1:0] r3_z;
    logic           r3_ovf, r3_udf, r3_nx, r3_nv;

    // Stage 3 / output registers; held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_v   <= 1'b0;
            r3_z   <= '0;
            r3_ovf <= 1'b0;
            r3_udf <= 1'b0;
            r3_nx  <= 1'b0;
            r3_nv  <= 1'b0;
        end else if (w_en3) begin
            r3_v <= r2_v;
            if (r2_v) begin
                r3_z   <= w_z;
                r3_ovf <= w_ovf;
                r3_udf <= w_udf;
                r3_nx  <= w_nx;
                r3_nv  <= w_nv;
            end
        end
    end

    assign out_valid = r3_v;
    assign fp_Z      = r3_z;
    assign ovrf      = r3_ovf;
    assign udrf      = r3_udf;
    assign nx        = r3_nx;
    assign nv        = r3_nv;

endmodule
`default_nettype wire

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. It generalises the single-precision combinational multiplier to any exponent and fraction width. It registers the datapath into three stages (multiply, normalise, round/pack), holds results under output backpressure, and adds the full exception-flag set. It sits between the FPU operand issue logic and the result writeback arbiter.

## Interface
- EXP_W, 8: exponent width; bias = 2^(EXP_W-1)-1.
- FRC_W, 23: stored fraction width; word width W = 1+EXP_W+FRC_W.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all pipeline state.
- in_valid  in  1  operand pair and mode present.
- in_ready  out  1  stage 1 can accept; transfer when in_valid && in_ready.
- fp_X, fp_Y  in  W  operands.
- r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- fp_Z  out  W  product.
- ovrf, udrf, nx, nv  out  1 each  overflow, underflow, inexact, invalid; valid with fp_Z.

## Operation
- Classification:
  - Exponent all-zero is treated as zero; subnormal inputs are flushed with no flag.
  - Exponent all-ones with fraction 0 is infinity; with fraction ≠ 0 it is NaN.
- Result sign is always fp_X[W-1] ^ fp_Y[W-1], except for NaN results.
- Special results, which bypass rounding:
  - Any NaN input gives canonical qNaN {0, all-ones exponent, 1, zeros}; nv=1 only if an input is signalling (fraction MSB = 0).
  - Inf×zero gives canonical qNaN with nv=1.
  - Inf×finite-nonzero or inf×inf gives signed infinity, no flags.
  - Zero×finite gives signed zero, no flags.
- Stage 1 (multiply):
  - P = {1,frcX}×{1,frcY}, 2·FRC_W+2 bits.
  - E = eX+eY-bias, signed, EXP_W+2 bits.
  - Capture sign, r_mode and special-case result.
- Stage 2 (normalise):
  - If P MSB = 1, keep P and E+1; else shift P left by 1 and keep E.
  - Keep a FRC_W+1-bit significand (leading 1 plus fraction), guard G, round R, and sticky S = OR of the remaining bits.
- Stage 3 (round/pack):
  - Increment condition per mode:
    - RNE: G && (R||S||lsb).
    - RTZ: never.
    - RDN: sign && (G||R||S).
    - RUP: !sign && (G||R||S).
    - RMM: G.
  - nx = G||R||S.
  - A carry out of the significand on increment sets the fraction to 0 and adds 1 to E.
- Overflow (E ≥ 2^EXP_W-1 after rounding): ovrf=1, nx=1.
  - RNE, RMM: ±inf.
  - RTZ: ±max finite.
  - RDN: -inf if negative, else +max finite.
  - RUP: +inf if positive, else -max finite.
- Underflow (E ≤ 0 after rounding): result is signed zero, udrf=1, nx=1. Subnormal outputs are never produced.

## Timing
- Latency is 3 cycles from input transfer to out_valid, with no stalls. Throughput is 1 result per cycle.
- Each stage holds a valid bit. Stage k loads when it is empty or when stage k+1 loads/drains.
- in_ready is combinational from out_ready and the stage valids. It is 1 when any stage is empty or out_ready=1. Bubbles are collapsed.
- Results leave strictly in input order, with no loss or duplication.
- While out_valid=1 and out_ready=0, fp_Z and all flags hold stable.
- A simultaneous input transfer and output transfer with all stages full is legal and keeps the pipeline full.
- Reset values:
  - All stage valids 0; out_valid=0; fp_Z=0; ovrf=udrf=nx=nv=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight operations; no partial result is emitted.
- Each operation uses the r_mode captured with it, so mode changes between operations are safe.

## Test plan
- 0x3FC00000×0x40000000, RNE, out_ready=1 → 0x40400000 three cycles after acceptance, all flags 0.
- 0x3F800001×0x3F800001:
  - RNE → 0x3F800002, nx=1.
  - RTZ → 0x3F800002, nx=1.
  - RUP → 0x3F800003, nx=1.
- 0x7F000000×0x40000000:
  - RNE → 0x7F800000, ovrf=1, nx=1.
  - RTZ → 0x7F7FFFFF, ovrf=1, nx=1.
  - 0x80800000×0x00800000, RNE → 0x80000000, udrf=1, nx=1.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, nv=1.
  - 0x80000001×0x3F800000 → 0x80000000, no flags.
  - 0x7F800001×0x3F800000 → 0x7FC00000, nv=1.
- Backpressure with out_ready=0:
  - Offer 5 consecutive operations → exactly 3 accepted, then in_ready=0, and out_valid output stays stable.
  - Raise out_ready → all 5 results in order, 1 per cycle.
- Assert rst with 3 operations in flight → next cycle out_valid=0 and in_ready=1; the first new operation returns after 3 cycles with the correct value.
